unit_dispatcher: RTL

Parametrised, stateful successor to the instruction-type enable decoder. It accepts a decoded instruction type over a valid/ready handshake and maps it through a programmable table to one functional unit. It holds that unit's one-hot enable until the unit signals done or a watchdog expires. It sits between the decode stage and the execution units (ALU, STACK, JMP, DMA, SCHED, UART) and provides back-pressure, illegal-type and timeout reporting.

---
 rtl/unit_dispatcher_pkg.sv | 30 +++
 rtl/unit_dispatcher_watchdog.sv | 45 ++++
 rtl/unit_dispatcher.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/unit_dispatcher_pkg.sv
// Shared constants for the unit dispatcher: unit indices, type codes, default map.
// No logic; imported by the dispatcher and its watchdog.
// Default map: t0 illegal, t1 STACK, t2/t3 ALU, t4 DMA, t5 SCHED, t6 UART, t7 JMP.
package unit_dispatcher_pkg;

    localparam logic [2:0] UNIT_ALU   = 3'd0;
    localparam logic [2:0] UNIT_STACK = 3'd1;
    localparam logic [2:0] UNIT_JMP   = 3'd2;
    localparam logic [2:0] UNIT_DMA   = 3'd3;
    localparam logic [2:0] UNIT_SCHED = 3'd4;
    localparam logic [2:0] UNIT_UART  = 3'd5;
    localparam logic [2:0] UNIT_NONE  = 3'b111;

    localparam logic [2:0] TYPE_STACK = 3'b001;
    localparam logic [2:0] TYPE_ALU1  = 3'b010;
    localparam logic [2:0] TYPE_ALU2  = 3'b011;
    localparam logic [2:0] TYPE_DMA   = 3'b100;
    localparam logic [2:0] TYPE_SCHED = 3'b101;
    localparam logic [2:0] TYPE_UART  = 3'b110;
    localparam logic [2:0] TYPE_JMP   = 3'b111;

    localparam logic [23:0] DEFAULT_TYPE_MAP = {UNIT_JMP, UNIT_UART, UNIT_SCHED, UNIT_DMA,
                                                UNIT_ALU, UNIT_ALU, UNIT_STACK, UNIT_NONE};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } disp_state_e;

endpackage

// File: rtl/unit_dispatcher_watchdog.sv
// Busy-cycle watchdog: counts enabled cycles, flags expiry on count TIMEOUT-1.
// Latency: expire is combinational from the count; the count updates every clk edge.
// No backpressure; clr wins over en, TIMEOUT=0 never expires.
module dispatch_watchdog
    import unit_dispatcher_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    if (TIMEOUT > int'((64'd1 << CNT_W) - 64'd1)) begin : g_bad_timeout
        $error("dispatch_watchdog: TIMEOUT does not fit in CNT_W bits");
    end

    assign expire = (TIMEOUT != 0) && en && !clr && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || expire) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            // Saturate so a disabled watchdog never wraps back through LAST.
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/unit_dispatcher.sv
// Maps an instruction type to one functional unit and holds its one-hot enable until done or watchdog expiry.
// Latency: accept at edge N gives unit_enb/busy/illegal at N+1; done at edge M gives retire at M+1.
// Backpressure: in_ready is low while BUSY and during reset; one instruction in flight at a time.
module unit_dispatcher
    import unit_dispatcher_pkg::*;
#(
    parameter int TYPE_W    = 3,
    parameter int NUM_UNITS = 6,
    parameter int IDX_W     = 3,
    parameter logic [(2**TYPE_W)*IDX_W-1:0] TYPE_MAP = DEFAULT_TYPE_MAP,
    parameter int TIMEOUT   = 255,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [TYPE_W-1:0]    in_type,
    output logic [NUM_UNITS-1:0] unit_enb,
    input  logic [NUM_UNITS-1:0] unit_done,
    output logic                 busy,
    output logic                 retire,
    output logic                 illegal,
    output logic                 timeout,
    output logic [CNT_W-1:0]     retired_cnt
);

    localparam logic [IDX_W-1:0] IDX_LIMIT = IDX_W'(NUM_UNITS);

    if (NUM_UNITS >= 2**IDX_W) begin : g_bad_idx_w
        $error("unit_dispatcher: IDX_W too narrow to encode the no-unit index");
    end

    disp_state_e          state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NUM_UNITS-1:0] unit_enb_q, unit_enb_d;
    logic                 busy_q, busy_d;
    logic                 retire_q, retire_d;
    logic                 illegal_q, illegal_d;
    logic                 timeout_q, timeout_d;
    logic [CNT_W-1:0]     retired_cnt_q, retired_cnt_d;

    logic [IDX_W-1:0] map_tbl [2**TYPE_W];
    logic [IDX_W-1:0] map_idx;
    logic             done_sel;
    logic             wd_clr;
    logic             wd_en;
    logic             wd_expire;

    for (genvar t = 0; t < 2**TYPE_W; t++) begin : g_map
        assign map_tbl[t] = TYPE_MAP[t*IDX_W +: IDX_W];
    end

    assign map_idx  = map_tbl[in_type];
    assign in_ready = (state_q == ST_IDLE) && !rst;
    // Only the enabled unit's strobe can complete the instruction.
    assign done_sel = |(unit_done & unit_enb_q);
    assign wd_clr   = (state_q != ST_BUSY) || done_sel;
    assign wd_en    = (state_q == ST_BUSY) && !done_sel;

    dispatch_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (wd_expire)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        unit_enb_d    = unit_enb_q;
        busy_d        = busy_q;
        retire_d      = 1'b0;
        illegal_d     = 1'b0;
        timeout_d     = 1'b0;
        retired_cnt_d = retired_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    if (map_idx < IDX_LIMIT) begin
                        state_d    = ST_BUSY;
                        idx_d      = map_idx;
                        unit_enb_d = NUM_UNITS'(1) << map_idx;
                        busy_d     = 1'b1;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                unit_enb_d = NUM_UNITS'(1) << idx_q;
                // Done is checked first so it wins over a coincident expiry.
                if (done_sel || wd_expire) begin
                    state_d    = ST_IDLE;
                    idx_d      = '1;
                    unit_enb_d = '0;
                    busy_d     = 1'b0;
                    if (done_sel) begin
                        retire_d      = 1'b1;
                        retired_cnt_d = retired_cnt_q + CNT_W'(1);
                    end else begin
                        timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = ST_IDLE;
                idx_d      = '1;
                unit_enb_d = '0;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '1;
            unit_enb_q    <= '0;
            busy_q        <= 1'b0;
            retire_q      <= 1'b0;
            illegal_q     <= 1'b0;
            timeout_q     <= 1'b0;
            retired_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            unit_enb_q    <= unit_enb_d;
            busy_q        <= busy_d;
            retire_q      <= retire_d;
            illegal_q     <= illegal_d;
            timeout_q     <= timeout_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign unit_enb    = unit_enb_q;
    assign busy        = busy_q;
    assign retire      = retire_q;
    assign illegal     = illegal_q;
    assign timeout     = timeout_q;
    assign retired_cnt = retired_cnt_q;

endmodule
